// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
//   - default data and select widths
//   - zero-register option constants
//   - bypass_hit(): write-to-read select match, shared by both read ports
//     and by the write-after-write term in the scoreboard
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_ADDR_W = 2;

    // Widest select bypass_hit() compares; callers widen their selects to this.
    localparam int unsigned MAX_ADDR_W = 16;

    localparam bit ZERO_REG_OFF = 1'b0;
    localparam bit ZERO_REG_ON  = 1'b1;

    // True when a write this cycle targets the register being looked up.
    function automatic logic bypass_hit(
        input logic                  we,
        input logic [MAX_ADDR_W-1:0] wsel,
        input logic [MAX_ADDR_W-1:0] rsel
    );
        return we && (wsel == rsel);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard.
//   CLK, RST             clock, synchronous active-high reset
//   write_bit/selector_e writeback clears the destination pending bit
//   reserve_bit/selector_r issue request to mark a destination pending
//   selector_a/selector_b read selects checked for RAW hazards
//   pending_a/pending_b  source not yet available (same-cycle writeback resolves it)
//   stall                reservation refused this cycle (RAW or WAW hazard)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = ZERO_REG_OFF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              write_bit,
    input  logic [ADDR_W-1:0] selector_e,
    input  logic              reserve_bit,
    input  logic [ADDR_W-1:0] selector_r,
    input  logic [ADDR_W-1:0] selector_a,
    input  logic [ADDR_W-1:0] selector_b,
    output logic              pending_a,
    output logic              pending_b,
    output logic              stall
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending_r;
    logic [DEPTH-1:0] pending_nxt_s;
    logic             hit_a_s;
    logic             hit_b_s;
    logic             hit_r_s;
    logic             pend_a_s;
    logic             pend_b_s;
    logic             waw_s;
    logic             stall_s;
    logic             accept_s;

    // Hazard detection: a writeback landing this cycle resolves the hazard.
    always_comb begin
        hit_a_s  = bypass_hit(write_bit, MAX_ADDR_W'(selector_e), MAX_ADDR_W'(selector_a));
        hit_b_s  = bypass_hit(write_bit, MAX_ADDR_W'(selector_e), MAX_ADDR_W'(selector_b));
        hit_r_s  = bypass_hit(write_bit, MAX_ADDR_W'(selector_e), MAX_ADDR_W'(selector_r));
        pend_a_s = pending_r[selector_a] & ~hit_a_s;
        pend_b_s = pending_r[selector_b] & ~hit_b_s;
        waw_s    = reserve_bit & pending_r[selector_r] & ~hit_r_s;
        stall_s  = (reserve_bit & (pend_a_s | pend_b_s)) | waw_s;
        accept_s = reserve_bit & ~stall_s;
    end

    // Next pending vector: an accepted reservation beats a same-edge clear.
    always_comb begin
        pending_nxt_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_nxt_s[i] =
                (accept_s && (selector_r == ADDR_W'(i)) &&
                 ((ZERO_REG != ZERO_REG_ON) || (i != 0))) ||
                (pending_r[i] && !(write_bit && (selector_e == ADDR_W'(i))));
        end
    end

    // Pending state register with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    assign pending_a = pend_a_s;
    assign pending_b = pend_b_s;
    assign stall     = stall_s;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-to-read bypass, optional
// hardwired zero register and a pending scoreboard for in-flight results.
//   CLK, RST                 clock, synchronous active-high reset (clears data and pending)
//   selector_a/b, data_out_a/b  combinational read ports with bypass from data_in
//   write_bit, selector_e, data_in  writeback port
//   reserve_bit, selector_r  issue-stage reservation of a destination
//   pending_a/b              read source still in flight
//   stall                    issue must hold; reservation not accepted
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = ZERO_REG_OFF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] selector_a,
    input  logic [ADDR_W-1:0] selector_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              write_bit,
    input  logic [ADDR_W-1:0] selector_e,
    input  logic [DATA_W-1:0] data_in,
    input  logic              reserve_bit,
    input  logic [ADDR_W-1:0] selector_r,
    output logic              pending_a,
    output logic              pending_b,
    output logic              stall
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic              wr_en_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    // A write to the hardwired zero register is dropped entirely, which
    // also keeps it off the bypass path.
    assign wr_en_s = write_bit &&
                     !((ZERO_REG == ZERO_REG_ON) && (selector_e == '0));

    // Data array with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            regs_r <= '{default: '0};
        end else if (wr_en_s) begin
            regs_r[selector_e] <= data_in;
        end
    end

    // Read port A: zero-register mask, then bypass, then array.
    always_comb begin
        rd_a_s = '0;
        if ((ZERO_REG == ZERO_REG_ON) && (selector_a == '0)) begin
            rd_a_s = '0;
        end else if (bypass_hit(wr_en_s, MAX_ADDR_W'(selector_e), MAX_ADDR_W'(selector_a))) begin
            rd_a_s = data_in;
        end else begin
            rd_a_s = regs_r[selector_a];
        end
    end

    // Read port B: same structure as port A.
    always_comb begin
        rd_b_s = '0;
        if ((ZERO_REG == ZERO_REG_ON) && (selector_b == '0)) begin
            rd_b_s = '0;
        end else if (bypass_hit(wr_en_s, MAX_ADDR_W'(selector_e), MAX_ADDR_W'(selector_b))) begin
            rd_b_s = data_in;
        end else begin
            rd_b_s = regs_r[selector_b];
        end
    end

    assign data_out_a = rd_a_s;
    assign data_out_b = rd_b_s;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .CLK         (CLK),
        .RST         (RST),
        .write_bit   (write_bit),
        .selector_e  (selector_e),
        .reserve_bit (reserve_bit),
        .selector_r  (selector_r),
        .selector_a  (selector_a),
        .selector_b  (selector_b),
        .pending_a   (pending_a),
        .pending_b   (pending_b),
        .stall       (stall)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a default instance (8x4), a zero-register
// instance and a 16-bit x 8 instance, driven one cycle per vector.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default instance
    logic [1:0]  d_sa, d_sb, d_se, d_sr;
    logic        d_we, d_rsv;
    logic [7:0]  d_din, d_a, d_b;
    logic        d_pa, d_pb, d_st;
    // zero-register instance
    logic [1:0]  z_sa, z_sb, z_se, z_sr;
    logic        z_we, z_rsv;
    logic [7:0]  z_din, z_a, z_b;
    logic        z_pa, z_pb, z_st;
    // wide/deep instance
    logic [2:0]  w_sa, w_sb, w_se, w_sr;
    logic        w_we, w_rsv;
    logic [15:0] w_din, w_a, w_b;
    logic        w_pa, w_pb, w_st;

    regfile_sb u_d (
        .CLK(clk), .RST(rst), .selector_a(d_sa), .selector_b(d_sb),
        .data_out_a(d_a), .data_out_b(d_b), .write_bit(d_we), .selector_e(d_se),
        .data_in(d_din), .reserve_bit(d_rsv), .selector_r(d_sr),
        .pending_a(d_pa), .pending_b(d_pb), .stall(d_st)
    );

    regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1'b1)) u_z (
        .CLK(clk), .RST(rst), .selector_a(z_sa), .selector_b(z_sb),
        .data_out_a(z_a), .data_out_b(z_b), .write_bit(z_we), .selector_e(z_se),
        .data_in(z_din), .reserve_bit(z_rsv), .selector_r(z_sr),
        .pending_a(z_pa), .pending_b(z_pb), .stall(z_st)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u_w (
        .CLK(clk), .RST(rst), .selector_a(w_sa), .selector_b(w_sb),
        .data_out_a(w_a), .data_out_b(w_b), .write_bit(w_we), .selector_e(w_se),
        .data_in(w_din), .reserve_bit(w_rsv), .selector_r(w_sr),
        .pending_a(w_pa), .pending_b(w_pb), .stall(w_st)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  sa, sb, se, sr;
        logic        we, rsv;
        logic [15:0] din;
        logic [15:0] ea, eb;
        logic        epa, epb, est;
    } vec_t;

    typedef struct {
        int          inst;
        int          idx;
        logic [15:0] ea, eb;
        logic        epa, epb, est;
    } exp_t;

    exp_t sb_q[$];
    vec_t tv[21];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input int r, input int sa, input int sb, input int we,
                                input int se, input int din, input int rsv, input int sr,
                                input int ea, input int eb, input int epa, input int epb,
                                input int est);
        vec_t v;
        v.rst = 1'(r);   v.sa = 3'(sa);   v.sb = 3'(sb);   v.we = 1'(we);
        v.se = 3'(se);   v.din = 16'(din); v.rsv = 1'(rsv); v.sr = 3'(sr);
        v.ea = 16'(ea);  v.eb = 16'(eb);  v.epa = 1'(epa); v.epb = 1'(epb);
        v.est = 1'(est);
        return v;
    endfunction

    task automatic check(input string name, input int inst, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s inst%0d vec%0d: got %h, expected %h", name, inst, idx, act, exp);
        end
    endtask

    task automatic idle_all();
        d_we = 1'b0; d_rsv = 1'b0;
        z_we = 1'b0; z_rsv = 1'b0;
        w_we = 1'b0; w_rsv = 1'b0;
    endtask

    // Drive one vector after a rising edge, queue its expectation, compare
    // outputs on the falling edge before the state update.
    task automatic run(input int inst, input int idx, input vec_t v);
        exp_t e;
        logic [15:0] aa, ab;
        logic apa, apb, ast;
        @(posedge clk);
        #1;
        rst = v.rst;
        idle_all();
        case (inst)
            0: begin
                d_sa = v.sa[1:0]; d_sb = v.sb[1:0]; d_we = v.we; d_se = v.se[1:0];
                d_din = v.din[7:0]; d_rsv = v.rsv; d_sr = v.sr[1:0];
            end
            1: begin
                z_sa = v.sa[1:0]; z_sb = v.sb[1:0]; z_we = v.we; z_se = v.se[1:0];
                z_din = v.din[7:0]; z_rsv = v.rsv; z_sr = v.sr[1:0];
            end
            default: begin
                w_sa = v.sa; w_sb = v.sb; w_we = v.we; w_se = v.se;
                w_din = v.din; w_rsv = v.rsv; w_sr = v.sr;
            end
        endcase
        e.inst = inst; e.idx = idx; e.ea = v.ea; e.eb = v.eb;
        e.epa = v.epa; e.epb = v.epb; e.est = v.est;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        case (e.inst)
            0: begin aa = {8'h00, d_a}; ab = {8'h00, d_b}; apa = d_pa; apb = d_pb; ast = d_st; end
            1: begin aa = {8'h00, z_a}; ab = {8'h00, z_b}; apa = z_pa; apb = z_pb; ast = z_st; end
            default: begin aa = w_a; ab = w_b; apa = w_pa; apb = w_pb; ast = w_st; end
        endcase
        check("data_out_a", e.inst, e.idx, aa, e.ea);
        check("data_out_b", e.inst, e.idx, ab, e.eb);
        check("pending_a", e.inst, e.idx, {15'h0000, apa}, {15'h0000, e.epa});
        check("pending_b", e.inst, e.idx, {15'h0000, apb}, {15'h0000, e.epb});
        check("stall", e.inst, e.idx, {15'h0000, ast}, {15'h0000, e.est});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        d_sa = 2'd0; d_sb = 2'd0; d_se = 2'd0; d_sr = 2'd0; d_din = 8'h00;
        z_sa = 2'd0; z_sb = 2'd0; z_se = 2'd0; z_sr = 2'd0; z_din = 8'h00;
        w_sa = 3'd0; w_sb = 3'd0; w_se = 3'd0; w_sr = 3'd0; w_din = 16'h0000;
        idle_all();
        repeat (2) @(posedge clk);

        //          rst sa sb we se din       rsv sr  ea        eb        pa pb st
        tv[0]  = mk(0,  2, 3, 0, 0, 0,        0,  0,  0,        0,        0, 0, 0);
        tv[1]  = mk(0,  2, 0, 1, 2, 'hA5,     0,  0,  'hA5,     0,        0, 0, 0);
        tv[2]  = mk(0,  2, 2, 0, 0, 0,        0,  0,  'hA5,     'hA5,     0, 0, 0);
        tv[3]  = mk(1,  2, 1, 1, 1, 'h11,     1,  1,  'hA5,     'h11,     0, 0, 0);
        tv[4]  = mk(0,  2, 1, 0, 0, 0,        0,  0,  0,        0,        0, 0, 0);
        tv[5]  = mk(0,  1, 3, 0, 0, 0,        1,  3,  0,        0,        0, 0, 0);
        tv[6]  = mk(0,  1, 3, 1, 1, 'h3C,     0,  0,  'h3C,     0,        0, 1, 0);
        tv[7]  = mk(0,  3, 1, 0, 0, 0,        1,  1,  0,        'h3C,     1, 0, 1);
        tv[8]  = mk(0,  1, 3, 0, 0, 0,        0,  0,  'h3C,     0,        0, 1, 0);
        tv[9]  = mk(0,  3, 1, 1, 3, 'h77,     1,  2,  'h77,     'h3C,     0, 0, 0);
        tv[10] = mk(0,  3, 2, 0, 0, 0,        0,  0,  'h77,     0,        0, 1, 0);
        tv[11] = mk(0,  1, 3, 0, 0, 0,        1,  0,  'h3C,     'h77,     0, 0, 0);
        tv[12] = mk(0,  1, 3, 0, 0, 0,        1,  0,  'h3C,     'h77,     0, 0, 1);
        tv[13] = mk(0,  1, 0, 1, 0, 'h5A,     1,  0,  'h3C,     'h5A,     0, 0, 0);
        tv[14] = mk(0,  0, 2, 0, 0, 0,        0,  0,  'h5A,     0,        1, 1, 0);
        tv[15] = mk(0,  2, 1, 1, 1, 'hC3,     1,  1,  0,        'hC3,     1, 0, 1);
        tv[16] = mk(0,  1, 0, 0, 0, 0,        0,  0,  'hC3,     'h5A,     0, 1, 0);
        tv[17] = mk(0,  1, 3, 0, 0, 0,        1,  1,  'hC3,     'h77,     0, 0, 0);
        tv[18] = mk(0,  1, 1, 0, 0, 0,        0,  0,  'hC3,     'hC3,     1, 1, 0);
        tv[19] = mk(0,  0, 3, 1, 2, 'hE1,     0,  0,  'h5A,     'h77,     1, 0, 0);
        tv[20] = mk(0,  2, 2, 0, 0, 0,        0,  0,  'hE1,     'hE1,     0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            run(0, i, tv[i]);
        end

        // Zero register: writes and reservations to r0 are dropped.
        run(1, 0, mk(0, 0, 0, 1, 0, 'hFF, 0, 0, 0,     0, 0, 0, 0));
        run(1, 1, mk(0, 0, 0, 0, 0, 0,    0, 0, 0,     0, 0, 0, 0));
        run(1, 2, mk(0, 0, 1, 0, 0, 0,    1, 0, 0,     0, 0, 0, 0));
        run(1, 3, mk(0, 0, 0, 0, 0, 0,    1, 0, 0,     0, 0, 0, 0));
        run(1, 4, mk(0, 0, 1, 1, 1, 'h42, 0, 0, 0,     'h42, 0, 0, 0));
        run(1, 5, mk(0, 1, 0, 0, 0, 0,    1, 1, 'h42,  0, 0, 0, 0));
        run(1, 6, mk(0, 1, 0, 0, 0, 0,    0, 0, 'h42,  0, 1, 0, 0));

        // 16-bit x 8 instance: top register and neighbours.
        run(2, 0, mk(0, 6, 7, 1, 6, 'h1234, 0, 0, 'h1234, 0,      0, 0, 0));
        run(2, 1, mk(0, 7, 6, 1, 7, 'hBEEF, 0, 0, 'hBEEF, 'h1234, 0, 0, 0));
        run(2, 2, mk(0, 7, 7, 0, 0, 0,      0, 0, 'hBEEF, 'hBEEF, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            run(2, 3 + i, mk(0, i, 6, 0, 0, 0, 0, 0, 0, 'h1234, 0, 0, 0));
        end
        run(2, 9,  mk(0, 7, 0, 0, 0, 0, 1, 7, 'hBEEF, 0, 0, 0, 0));
        run(2, 10, mk(0, 7, 0, 0, 0, 0, 1, 7, 'hBEEF, 0, 1, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
